// File: rtl/sp_cmd_issuer.sv
// sp_cmd_issuer: writes a command and its arguments into the special-purpose BRAM, polls the status word, reports completion (optional poll timeout via SP_CMD_TIMEOUT_EN)
module sp_cmd_issuer #(
  parameter int NUM_VAR        = 4,
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_word,
  input  logic [32*NUM_VAR-1:0]  cmd_args,
  output logic [31:0]            addr_sp_bram,
  output logic                   enable_sp_bram,
  output logic [3:0]             w_enable_sp_bram,
  output logic [31:0]            data_in_sp_bram,
  input  logic [31:0]            data_out_sp_bram,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [6:0]             status_code,
  output logic                   timeout
);
  localparam logic [31:0] STAT = 32'(4 * (NUM_VAR + 1));
  typedef enum logic [3:0] {IDLE, WR_ARGS, WR_CMD, POLL_WAIT, POLL_RD, POLL_CHK, CLR_STAT, ABORT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cmd_q, arg_sel;
  logic [32*NUM_VAR-1:0] args_q;
  logic err_q, tmo, unused_hi;
  assign unused_hi = ^data_out_sp_bram[31:8];
`ifdef SP_CMD_TIMEOUT_EN
  logic [31:0] tcnt;
  logic to_q, poll;
  assign poll = state inside {POLL_WAIT, POLL_RD, POLL_CHK};
  assign tmo = poll && tcnt == 32'(TIMEOUT_CYCLES - 1);
  assign timeout = state == DONE && to_q;
  // poll budget counter, cleared whenever polling is not in progress
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      to_q <= 1'b0;
    end else begin
      tcnt <= poll ? tcnt + 32'd1 : 32'd0;
      if (state_n == DONE) to_q <= state == ABORT;
    end
`else
  logic unused_to;
  assign unused_to = TIMEOUT_CYCLES != 0;
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
  // state register, shared cycle counter, captured command and completion results
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_q       <= '0;
      args_q      <= '0;
      err_q       <= 1'b0;
      status_code <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == WR_ARGS || state == POLL_WAIT) ? cnt + 32'd1 : state == POLL_CHK ? 32'd1 : 32'd0;
      if (state == IDLE && cmd_valid) begin
        cmd_q  <= cmd_word;
        args_q <= cmd_args;
      end
      if (state_n == DONE) err_q <= state == IDLE || state == ABORT;
      if (state_n == CLR_STAT) status_code <= data_out_sp_bram[7:1];
    end
  // next state and BRAM/handshake outputs; a failed check counts as the first idle cycle of the next wait
  always_comb begin
    state_n = state;
    arg_sel = '0;
    for (int i = 0; i < NUM_VAR; i++)
      if (cnt == 32'(i)) arg_sel = args_q[32*i +: 32];
    case (state)
      IDLE:      state_n = !cmd_valid ? IDLE : cmd_word != 0 ? WR_ARGS : DONE;
      WR_ARGS:   state_n = cnt == 32'(NUM_VAR - 1) ? WR_CMD : WR_ARGS;
      WR_CMD:    state_n = POLL_WAIT;
      POLL_WAIT: state_n = cnt >= 32'(POLL_INTERVAL - 1) ? POLL_RD : POLL_WAIT;
      POLL_RD:   state_n = POLL_CHK;
      POLL_CHK:  state_n = data_out_sp_bram[0] ? CLR_STAT : POLL_WAIT;
      CLR_STAT:  state_n = DONE;
      ABORT:     state_n = DONE;
      default:   state_n = IDLE;
    endcase
    if (tmo) state_n = ABORT;
    cmd_ready        = state == IDLE;
    busy             = state != IDLE;
    done             = state == DONE;
    error            = state == DONE && err_q;
    enable_sp_bram   = state inside {WR_ARGS, WR_CMD, POLL_RD, CLR_STAT, ABORT};
    w_enable_sp_bram = state inside {WR_ARGS, WR_CMD, CLR_STAT, ABORT} ? 4'hF : 4'h0;
    addr_sp_bram     = state == WR_ARGS ? (cnt + 32'd1) << 2 : (state == POLL_RD || state == CLR_STAT) ? STAT : 32'd0;
    data_in_sp_bram  = state == WR_ARGS ? arg_sel : state == WR_CMD ? cmd_q : 32'd0;
  end
endmodule

// File: tb/tb_sp_cmd_issuer.sv
// tb_sp_cmd_issuer: directed bench for sp_cmd_issuer with a behavioural BRAM (define SP_CMD_TIMEOUT_EN for the timeout scenario)
module tb_sp_cmd_issuer;
  localparam logic [31:0] STAT = 32'h14;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [31:0] cmd_word = '0;
  logic [127:0] cmd_args = '0;
  logic cmd_ready, enable_sp_bram, busy, done, error, timeout;
  logic [31:0] addr_sp_bram, data_in_sp_bram;
  logic [31:0] data_out_sp_bram = '0;
  logic [3:0] w_enable_sp_bram;
  logic [6:0] status_code;
  logic [31:0] mem [0:15];
  int n_assert = 0, n_fail = 0, cyc = 0, done_cyc = 0, done_cnt = 0, en_cnt = 0, ready_seen = 0;
  int rd_t[$];
  logic d_err = 1'b0, d_to = 1'b0;
  logic [6:0] d_code = '0;
  logic [68:0] last_bus = '0;

  sp_cmd_issuer #(.NUM_VAR(4), .POLL_INTERVAL(16), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .cmd_args(cmd_args), .addr_sp_bram(addr_sp_bram),
    .enable_sp_bram(enable_sp_bram), .w_enable_sp_bram(w_enable_sp_bram),
    .data_in_sp_bram(data_in_sp_bram), .data_out_sp_bram(data_out_sp_bram),
    .busy(busy), .done(done), .error(error), .status_code(status_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    chk(tag, {enable_sp_bram, w_enable_sp_bram, addr_sp_bram, data_in_sp_bram}, {e, w, a, d});
  endtask

  // one clock: BRAM performs the access presented before the edge, then record what the DUT shows this cycle
  task automatic step();
    logic e;
    logic [3:0] w;
    logic [31:0] a, d;
    e = enable_sp_bram; w = w_enable_sp_bram; a = addr_sp_bram; d = data_in_sp_bram;
    @(posedge clk);
    #1;
    if (e) begin
      if (w != 0) mem[a[5:2]] = d;
      else data_out_sp_bram = mem[a[5:2]];
    end
    cyc++;
    if (enable_sp_bram) begin
      en_cnt++;
      if (w_enable_sp_bram == 0 && addr_sp_bram == STAT) rd_t.push_back(cyc);
    end
    if (cmd_ready) ready_seen++;
    if (done) begin
      done_cnt++; done_cyc = cyc; d_err = error; d_to = timeout; d_code = status_code;
    end else last_bus = {enable_sp_bram, w_enable_sp_bram, addr_sp_bram, data_in_sp_bram};
  endtask

  // present a command, take the accept edge; cyc=1 is the first cycle after accept
  task automatic start(input logic [31:0] w, input logic [127:0] a, input logic keep);
    cmd_word = w; cmd_args = a; cmd_valid = 1'b1;
    cyc = 0; done_cnt = 0; done_cyc = 0; en_cnt = 0; ready_seen = 0; rd_t.delete();
    step();
    cmd_valid = keep;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = 32'h0000_000B;
    #2;
    chk("rst_bus", {enable_sp_bram, w_enable_sp_bram, addr_sp_bram, data_in_sp_bram}, 69'd0);
    chk("rst_flags", {done, error, timeout, busy, cmd_ready}, 5'b00001);
    chk("rst_code", status_code, 7'd0);
    step(); step();
    reset = 1'b0;
    step();

    start(32'd1, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0);
    for (int i = 1; i <= 26; i++) begin
      if (i > 1) step();
      if (i <= 4) chk_bus($sformatf("s1_arg%0d", i - 1), 1'b1, 4'hF, 32'(4 * i), 32'hA + 32'(i - 1));
      else if (i == 5) chk_bus("s1_go", 1'b1, 4'hF, 32'h0, 32'h1);
      else if (i == 22) chk_bus("s1_rd", 1'b1, 4'h0, STAT, 32'h0);
      else if (i == 24) chk_bus("s1_clr", 1'b1, 4'hF, STAT, 32'h0);
      else if (i == 25) chk("s1_done", {done, error, timeout, busy, cmd_ready, status_code}, {5'b10010, 7'd5});
      else if (i == 26) chk("s1_idle", {done, busy, cmd_ready}, 3'b001);
    end
    chk("s1_done_cyc", done_cyc, 25);
    chk("s1_en_cnt", en_cnt, 7);
    chk("s1_reads", rd_t.size(), 1);
    chk("s1_mem", {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]}, {32'h1, 32'hA, 32'hB, 32'hC, 32'hD, 32'h0});

    start(32'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    for (int i = 0; i < 150 && done_cnt == 0; i++) begin
      step();
      if (rd_t.size() == 3 && cyc == rd_t[2] + 1) mem[5] = 32'h1;
    end
    chk("s2_done_cyc", done_cyc, 76);
    chk("s2_reads", rd_t.size(), 4);
    if (rd_t.size() >= 4)
      chk("s2_read_times", {rd_t[0], rd_t[1] - rd_t[0], rd_t[2] - rd_t[1], rd_t[3] - rd_t[2]}, {32'd22, 32'd17, 32'd17, 32'd17});
    chk("s2_result", {d_err, d_to, d_code}, 9'd0);
    chk("s2_busy_reject", ready_seen, 0);
    cmd_args = {32'h99, 32'h88, 32'h77, 32'h66};
    step();
    chk("s2_idle_gap", {done, busy, cmd_ready}, 3'b001);
    step();
    chk("s2_reaccept", busy, 1'b1);
    chk_bus("s2_new_arg0", 1'b1, 4'hF, 32'h4, 32'h66);
    cmd_valid = 1'b0;
    step();
    chk_bus("s3_arg1_pre", 1'b1, 4'hF, 32'h8, 32'h77);
    #3 reset = 1'b1;
    #1;
    chk_bus("s3_rst_bus", 1'b0, 4'h0, 32'h0, 32'h0);
    chk("s3_rst_flags", {busy, cmd_ready, done, status_code}, {3'b010, 7'd0});
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("s3_after", {busy, cmd_ready}, 2'b01);
    chk("s3_no_done", done_cnt, 1);
    chk("s3_mem", {mem[1], mem[2]}, {32'h66, 32'h22});

    start(32'd0, {4{32'h5A5A}}, 1'b0);
    chk("s4_done", {done, error, timeout, busy}, 4'b1101);
    step();
    chk("s4_idle", {done, cmd_ready}, 2'b01);
    step();
    chk("s4_no_access", en_cnt, 0);

`ifdef SP_CMD_TIMEOUT_EN
    mem[5] = 32'h0;
    start(32'd7, {4{32'h5}}, 1'b0);
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    chk("s5_done_cyc", done_cyc, 47);
    chk("s5_result", {d_err, d_to}, 2'b11);
    chk("s5_abort_bus", last_bus, {1'b1, 4'hF, 32'h0, 32'h0});
    chk("s5_mem0", mem[0], 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sp_cmd_issuer.md
SP_CMD_ISSUER -- requirements
Module: sp_cmd_issuer

Interface
REQ-001 Parameters SHALL be:
- NUM_VAR, default 4: argument words per command.
- POLL_INTERVAL, default 16: idle cycles before each status read.
- TIMEOUT_CYCLES, default 65535: poll budget, used only with SP_CMD_TIMEOUT_EN.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- cmd_valid, in, 1: host offers a command.
- cmd_ready, out, 1: issuer can accept a command.
- cmd_word, in, 32: command/go word.
- cmd_args, in, 32*NUM_VAR: argument k is bits [32k+31:32k].
- addr_sp_bram, out, 32: byte address into the special-purpose BRAM.
- enable_sp_bram, out, 1: BRAM port enable.
- w_enable_sp_bram, out, 4: byte write enables.
- data_in_sp_bram, out, 32: write data to the BRAM.
- data_out_sp_bram, in, 32: read data, valid 1 cycle after the read cycle.
- busy, out, 1: command in flight.
- done, out, 1: one-cycle completion pulse.
- error, out, 1: valid with done.
- status_code, out, 7: valid with done.
- timeout, out, 1: valid with done.

Function
REQ-003 Memory map SHALL be: command word at byte 0x0; argument k at 4*(k+1); status word at STAT = 4*(NUM_VAR+1), which is 0x14 at defaults.
REQ-004 Accept SHALL occur on the edge where cmd_valid && cmd_ready; cmd_word and cmd_args SHALL be captured at that edge and held until the command completes.
REQ-005 cmd_ready SHALL be 1 only in state IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-006 busy SHALL equal (state != IDLE).
REQ-007 States SHALL be IDLE, WR_ARGS, WR_CMD, POLL_WAIT, POLL_RD, POLL_CHK, CLR_STAT, ABORT, DONE.
REQ-008 IDLE->WR_ARGS on accept with cmd_word != 0; IDLE->DONE on accept with cmd_word == 0, with error=1 and no BRAM access.
REQ-009 WR_ARGS SHALL last NUM_VAR cycles; in cycle k: enable=1, w_enable=4'hF, addr=4*(k+1), data_in=arg k.
REQ-010 WR_CMD SHALL last 1 cycle writing cmd_word to address 0, so the go word lands after all arguments.
REQ-011 POLL_WAIT SHALL last POLL_INTERVAL cycles with enable=0.
REQ-012 POLL_RD SHALL last 1 cycle: enable=1, w_enable=0, addr=STAT.
REQ-013 POLL_CHK SHALL sample data_out_sp_bram: bit0=1 -> CLR_STAT and latch bits[7:1] into status_code; otherwise -> POLL_WAIT.
REQ-014 CLR_STAT SHALL last 1 cycle writing 0 to STAT with w_enable=4'hF, then go to DONE.
REQ-015 DONE SHALL last 1 cycle with done=1 and error/status_code/timeout valid, then go to IDLE.
REQ-016 In every state not listed as accessing the BRAM: enable=0, w_enable=0, addr=0, data_in=0.
REQ-017 Outside DONE: done=0, error=0, timeout=0; status_code holds its last value.
REQ-018 At most one BRAM access SHALL occur per cycle; no read and write SHALL be issued in the same cycle.

Reset
REQ-019 reset asserted SHALL force IDLE immediately, including mid-operation, with no clock needed.
REQ-020 During reset: all BRAM outputs 0, done=0, error=0, timeout=0, status_code=0, busy=0, cmd_ready=1.
REQ-021 All counters and captured command registers SHALL clear on reset; BRAM contents are not restored.

Configuration
REQ-022 With SP_CMD_TIMEOUT_EN defined:
- A counter SHALL start at WR_CMD exit and increment every cycle in the poll states.
- When it reaches TIMEOUT_CYCLES, the next state SHALL be ABORT.
- ABORT SHALL last 1 cycle writing 0 to address 0, then go to DONE with error=1 and timeout=1.
REQ-023 Without SP_CMD_TIMEOUT_EN: no counter, polling continues indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-024 The bench SHALL cover these scenarios at default parameters:
- Status preset: cmd_word=1, args 0xA,0xB,0xC,0xD, STAT memory preset to 0x0000000B -> writes 0x4=A, 0x8=B, 0xC=C, 0x10=D, then 0x0=1, then a read of 0x14; done high exactly 25 cycles after the accept edge; status_code=5; error=0; then 0x14 written to 0.
- Late status: STAT=0 for 3 polls, then 1 -> exactly 4 reads of 0x14, each 17 cycles apart, then a single done.
- Zero command: cmd_word=0 -> done 1 cycle after accept, error=1, enable_sp_bram never asserted.
- Reset mid-write: reset during WR_ARGS cycle 2 -> enable=0 within the same cycle; cmd_ready=1 and busy=0 after release; no done.
- Timeout (macro on, TIMEOUT_CYCLES=40, STAT never set): ABORT writes 0 to 0x0; done with error=1, timeout=1.
- Busy rejection: cmd_valid held high while busy -> no second accept until done plus 1 cycle.
